// File: rtl/ibex_rf_erase_sequencer.sv
// Register file write-side initiator: arbitrates bulk zero-erase writes against core
// writebacks with a bounded-starvation policy and drives the one-hot secure write enable.
module ibex_rf_erase_sequencer #(
    parameter bit          RV32E       = 1'b0,
    parameter int unsigned DataWidth   = 32,
    parameter int unsigned StarveLimit = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,

    input  logic                 ers_req_valid_i,
    output logic                 ers_req_ready_o,
    input  logic [31:0]          ers_mask_i,
    output logic                 ers_busy_o,
    output logic                 ers_done_o,

    input  logic                 wb_we_i,
    input  logic [4:0]           wb_waddr_i,
    input  logic [DataWidth-1:0] wb_wdata_i,
    output logic                 wb_stall_o,

    output logic                 rf_we_o,
    output logic [4:0]           rf_waddr_o,
    output logic [DataWidth-1:0] rf_wdata_o,
    output logic [31:0]          rf_we_secure_o
);

    localparam int unsigned        StarveW      = $clog2(StarveLimit + 1);
    localparam logic [StarveW-1:0] StarveMax    = StarveW'(StarveLimit);
    // x0 is hardwired and never erased; RV32E only has x1..x15.
    localparam logic [31:0]        ErasableMask = RV32E ? 32'h0000_FFFE : 32'hFFFF_FFFE;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        pending_q, pending_d;
    logic [StarveW-1:0] starve_q, starve_d;
    logic               core_wr;
    logic [4:0]         target;
    logic [31:0]        req_mask;

    // Writes to x0 are dropped and never contend with the erase sequence.
    assign core_wr  = wb_we_i & (wb_waddr_i != 5'd0);
    assign req_mask = ers_mask_i & ErasableMask;

    // Lowest set pending bit; scanning downward lets the lowest index win.
    always_comb begin
        target = 5'd0;
        for (int i = 31; i >= 1; i--) begin
            if (pending_q[i]) begin
                target = 5'(i);
            end
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d         = state_q;
        pending_d       = pending_q;
        starve_d        = '0;
        ers_req_ready_o = 1'b0;
        ers_busy_o      = 1'b0;
        ers_done_o      = 1'b0;
        wb_stall_o      = 1'b0;
        rf_we_o         = core_wr;
        rf_waddr_o      = wb_waddr_i;
        rf_wdata_o      = wb_wdata_i;

        unique case (state_q)
            StIdle: begin
                ers_req_ready_o = 1'b1;
                if (ers_req_valid_i) begin
                    pending_d = req_mask;
                    state_d   = (req_mask != '0) ? StScan : StDone;
                end
            end
            StScan: begin
                ers_busy_o = 1'b1;
                if (core_wr && (starve_q < StarveMax)) begin
                    // Core write wins; a newer value for a pending register supersedes its erase.
                    starve_d  = starve_q + 1'b1;
                    pending_d = pending_q & ~(32'd1 << wb_waddr_i);
                end else begin
                    wb_stall_o = core_wr;
                    rf_we_o    = 1'b1;
                    rf_waddr_o = target;
                    rf_wdata_o = '0;
                    pending_d  = pending_q & ~(32'd1 << target);
                end
                if (pending_d == '0) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                ers_busy_o = 1'b1;
                ers_done_o = 1'b1;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign rf_we_secure_o = rf_we_o ? (32'd1 << rf_waddr_o) : 32'd0;

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            pending_q <= '0;
            starve_q  <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            starve_q  <= starve_d;
        end
    end

endmodule

// File: tb/tb_ibex_rf_erase_sequencer.sv
// Directed and randomized checks of ibex_rf_erase_sequencer against a register-file-level
// reference model (erase applied at acceptance, then core writes in program order).
module tb_ibex_rf_erase_sequencer;

    localparam int StarveLimit = 4;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        ers_req_valid_i;
    logic [31:0] ers_mask_i;
    logic        wb_we_i;
    logic [4:0]  wb_waddr_i;
    logic [31:0] wb_wdata_i;

    logic        ready, busy, done, stall, rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata, rf_sec;
    logic        e_ready, e_busy, e_done, e_stall, e_rf_we;
    logic [4:0]  e_rf_waddr;
    logic [31:0] e_rf_wdata, e_rf_sec;

    int n_pass  = 0;
    int n_total = 0;

    logic [31:0] shadow [32];
    logic [31:0] mref   [32];

    always #5 clk_i = ~clk_i;

    ibex_rf_erase_sequencer #(.RV32E(1'b0), .DataWidth(32), .StarveLimit(StarveLimit)) u_dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .ers_req_valid_i(ers_req_valid_i), .ers_req_ready_o(ready), .ers_mask_i(ers_mask_i),
        .ers_busy_o(busy), .ers_done_o(done),
        .wb_we_i(wb_we_i), .wb_waddr_i(wb_waddr_i), .wb_wdata_i(wb_wdata_i), .wb_stall_o(stall),
        .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata), .rf_we_secure_o(rf_sec)
    );

    ibex_rf_erase_sequencer #(.RV32E(1'b1), .DataWidth(32), .StarveLimit(StarveLimit)) u_dut_e (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .ers_req_valid_i(ers_req_valid_i), .ers_req_ready_o(e_ready), .ers_mask_i(ers_mask_i),
        .ers_busy_o(e_busy), .ers_done_o(e_done),
        .wb_we_i(wb_we_i), .wb_waddr_i(wb_waddr_i), .wb_wdata_i(wb_wdata_i), .wb_stall_o(e_stall),
        .rf_we_o(e_rf_we), .rf_waddr_o(e_rf_waddr), .rf_wdata_o(e_rf_wdata), .rf_we_secure_o(e_rf_sec)
    );

    // Register file image as actually written by the main DUT.
    always @(posedge clk_i) begin
        if (rf_we) shadow[rf_waddr] <= rf_wdata;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    // Drive one cycle's inputs after the falling edge; outputs are observed 1 time unit later.
    task automatic drive(input logic v, input logic [31:0] m, input logic we,
                         input logic [4:0] a, input logic [31:0] d);
        @(negedge clk_i);
        ers_req_valid_i = v;
        ers_mask_i      = m;
        wb_we_i         = we;
        wb_waddr_i      = a;
        wb_wdata_i      = d;
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ers_req_valid_i = 1'b0;
        ers_mask_i      = '0;
        wb_we_i         = 1'b0;
        wb_waddr_i      = '0;
        wb_wdata_i      = '0;

        // Reset state
        repeat (2) @(negedge clk_i);
        #1;
        check("rst_ready", ready, 1);
        check("rst_busy",  busy,  0);
        check("rst_done",  done,  0);
        check("rst_stall", stall, 0);
        rst_ni = 1'b1;

        // Idle passthrough
        drive(0, 0, 1, 5, 32'hDEADBEEF);
        check("idle_we",    rf_we,    1);
        check("idle_waddr", rf_waddr, 5);
        check("idle_wdata", rf_wdata, 32'hDEADBEEF);
        check("idle_sec",   rf_sec,   32'h0000_0020);
        drive(0, 0, 1, 0, 32'h1111);
        check("idle_x0_we",  rf_we,  0);
        check("idle_x0_sec", rf_sec, 0);

        // Uncontended erase of x1..x3, with a second request held while busy
        drive(1, 32'hE, 0, 0, 0);
        check("unc_accept_ready", ready, 1);
        for (int c = 1; c <= 6; c++) begin
            drive(c <= 3, 32'h40, 0, 0, 0);
            if (c <= 3) begin
                check("unc_we",    rf_we,    1);
                check("unc_waddr", rf_waddr, c);
                check("unc_wdata", rf_wdata, 0);
                check("unc_sec",   rf_sec,   32'd1 << c);
                check("unc_busy_ready", {busy, ready}, 2'b10);
            end else if (c == 4) begin
                check("unc_done",  {done, busy, ready, rf_we}, 4'b1100);
            end else begin
                check("unc_idle",  {done, busy, ready, rf_we}, 4'b0010);
            end
        end

        // Starvation bound: StarveLimit core writes pass, then the core is stalled
        drive(1, 32'h100, 0, 0, 0);
        for (int c = 1; c <= 6; c++) begin
            drive(0, 0, 1, 9, 32'h9000 + c);
            if (c <= StarveLimit) begin
                check("stv_pass_stall", stall, 0);
                check("stv_pass_waddr", rf_waddr, 9);
                check("stv_pass_wdata", rf_wdata, 32'h9000 + c);
            end else if (c == StarveLimit + 1) begin
                check("stv_stall", stall, 1);
                check("stv_erase", {rf_we, rf_waddr, rf_wdata}, {1'b1, 5'd8, 32'd0});
            end else begin
                check("stv_done", {done, stall}, 2'b10);
                check("stv_done_pass", rf_waddr, 9);
            end
        end

        // Supersession: core write to x5 cancels its erase
        drive(0, 0, 1, 4, 32'hAAAA);
        drive(1, 32'h30, 0, 0, 0);
        drive(0, 0, 1, 5, 32'h1234);
        check("sup_pass", {stall, rf_we, rf_waddr, rf_wdata}, {1'b0, 1'b1, 5'd5, 32'h1234});
        drive(0, 0, 0, 0, 0);
        check("sup_erase", {rf_we, rf_waddr, rf_wdata}, {1'b1, 5'd4, 32'd0});
        drive(0, 0, 0, 0, 0);
        check("sup_done", done, 1);
        drive(0, 0, 0, 0, 0);
        check("sup_x5", shadow[5], 32'h1234);
        check("sup_x4", shadow[4], 0);

        // Degenerate mask
        drive(1, 32'h1, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        check("deg_done", {done, busy, rf_we}, 3'b110);
        drive(0, 0, 0, 0, 0);
        check("deg_idle", {ready, busy}, 2'b10);

        // RV32E instance erases only x1; the full instance also erases x16 and x31
        drive(1, 32'h8001_0002, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        check("e32_erase", {e_rf_we, e_rf_waddr, e_rf_wdata}, {1'b1, 5'd1, 32'd0});
        check("e32_sec",   e_rf_sec, 32'h2);
        check("e32_busy",  {e_busy, e_ready, e_stall}, 3'b100);
        check("full_x1",   rf_waddr, 1);
        drive(0, 0, 0, 0, 0);
        check("e32_done",  {e_done, e_rf_we}, 2'b10);
        check("full_x16",  rf_waddr, 16);
        drive(0, 0, 0, 0, 0);
        check("e32_idle",  e_ready, 1);
        check("full_x31",  rf_waddr, 31);
        drive(0, 0, 0, 0, 0);
        check("full_done", done, 1);

        // Mid-sequence reset
        drive(1, 32'hFFFF_FFFE, 0, 0, 0);
        for (int c = 1; c <= 3; c++) begin
            drive(0, 0, 0, 0, 0);
            check("mrst_erase", {rf_we, rf_waddr}, {1'b1, 5'(c)});
        end
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        check("mrst_outputs", {ready, busy, done, stall, rf_we}, 5'b10000);
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int c = 0; c < 4; c++) begin
            drive(0, 0, 0, 0, 0);
            check("mrst_quiet", {busy, rf_we}, 2'b00);
        end

        // Randomized: preload every register, then random erase masks under random core traffic
        for (int i = 1; i < 32; i++) begin
            mref[i] = $urandom;
            drive(0, 0, 1, 5'(i), mref[i]);
        end
        for (int it = 0; it < 25; it++) begin
            logic [31:0] m, eff;
            logic        hw, seen;
            logic [4:0]  ha;
            logic [31:0] hd;
            int          n, scan, budget;
            m = $urandom;
            if (it % 3 == 1) m = m & $urandom & $urandom;
            if (it == 7) m = 32'h1;
            eff = m & 32'hFFFF_FFFE;
            n   = $countones(eff);
            hw  = 1'($urandom_range(0, 1));
            ha  = 5'($urandom_range(0, 31));
            hd  = $urandom;
            drive(1, m, hw, ha, hd);
            check("rnd_accept_ready", ready, 1);
            if (hw && ha != 0) mref[ha] = hd;
            for (int i = 1; i < 32; i++) if (eff[i]) mref[i] = 32'd0;
            hw     = 1'b0;
            seen   = 1'b0;
            scan   = 0;
            budget = n * (StarveLimit + 1) + 2;
            while (!seen && scan <= budget) begin
                if (!hw) begin
                    hw = ($urandom_range(0, 3) != 0);
                    ha = 5'($urandom_range(0, 31));
                    hd = $urandom;
                end
                drive(0, 0, hw, ha, hd);
                check("rnd_sec_bit0", rf_sec[0], 0);
                check("rnd_sec", rf_sec, rf_we ? (32'd1 << rf_waddr) : 32'd0);
                if (done) begin
                    seen = 1'b1;
                    check("rnd_done_nostall", stall, 0);
                    if (hw && ha != 0) mref[ha] = hd;
                    hw = 1'b0;
                end else begin
                    scan++;
                    check("rnd_busy", {busy, ready}, 2'b10);
                    check("rnd_stall_cond", stall && !(hw && ha != 0), 0);
                    if (stall) begin
                        check("rnd_stall_erase", {rf_we, rf_wdata}, {1'b1, 32'd0});
                    end else begin
                        if (hw && ha != 0) mref[ha] = hd;
                        hw = 1'b0;
                    end
                end
            end
            check("rnd_done_seen", seen, 1);
            check("rnd_latency_bound", scan <= n * (StarveLimit + 1), 1);
            drive(0, 0, 0, 0, 0);
            check("rnd_idle", {ready, busy, stall}, 3'b100);
            for (int i = 1; i < 32; i++) check("rnd_regfile", shadow[i], mref[i]);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ibex_rf_erase_sequencer.md
Name: ibex_rf_erase_sequencer

Overview:
- Write-side initiator for the Ibex register file, sitting between the core writeback stage and the register file write port.
- Accepts a bulk erase request (a 32-bit register mask) and issues one zero-write per cycle to each selected architectural register.
- Interleaves these erase writes with core writebacks under a bounded-starvation arbitration policy.
- Also drives the one-hot secure write-enable vector used when the register file is built with secure write gating.

Parameters:
- RV32E, 0: when 1, only x1..x15 are erasable; mask bits 31:16 are ignored.
- DataWidth, 32: register data width.
- StarveLimit, 4: maximum consecutive erase-eligible cycles yielded to core writebacks before the core is stalled; must be ≥1.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- ers_req_valid_i  in  1  erase request valid
- ers_req_ready_o  out  1  erase request ready
- ers_mask_i  in  32  bit i set = erase xi
- ers_busy_o  out  1  sequence in progress
- ers_done_o  out  1  one-cycle pulse when sequence completes
- wb_we_i  in  1  core writeback enable
- wb_waddr_i  in  5  core writeback address
- wb_wdata_i  in  DataWidth  core writeback data
- wb_stall_o  out  1  core must hold its writeback this cycle
- rf_we_o  out  1  register file write enable
- rf_waddr_o  out  5  register file write address
- rf_wdata_o  out  DataWidth  register file write data
- rf_we_secure_o  out  32  one-hot secure write enable

Behaviour:
- Clock and reset: clk_i is the clock; rst_ni is asynchronous and active-low.
- Reset values:
  - State is IDLE; pending mask = 0; starve counter = 0.
  - ers_req_ready_o=1, ers_busy_o=0, ers_done_o=0, wb_stall_o=0.
  - rf_* outputs follow the IDLE combinational rule below.
- A reset asserted mid-sequence discards all pending erases.
- Core writes to x0: a core write with wb_waddr_i==0 is suppressed (rf_we_o=0) and does not count as a contending write.
- IDLE:
  - ers_req_ready_o=1.
  - rf_we_o = wb_we_i & (wb_waddr_i!=0); rf_waddr_o = wb_waddr_i; rf_wdata_o = wb_wdata_i.
  - On valid&ready, load pending = ers_mask_i with bit0 cleared (and bits 31:16 cleared if RV32E). Go to SCAN if pending≠0, else go to DONE.
- SCAN:
  - ers_busy_o=1, ers_req_ready_o=0. Target = lowest set bit of pending.
  - If a core write is present and starve < StarveLimit:
    - Pass the core write through; starve++.
    - If wb_waddr_i is set in pending, clear that bit (the newer value supersedes the erase).
  - If a core write is present and starve == StarveLimit:
    - wb_stall_o=1 (combinational, same cycle); core write is not performed.
    - Issue erase: rf_we_o=1, rf_waddr_o=target, rf_wdata_o=0. Clear target bit; starve=0.
  - If no core write is present: issue the erase as above; starve=0.
  - When pending becomes 0 (by erase or by supersession), go to DONE next cycle.
- DONE:
  - Lasts one cycle: ers_done_o=1, ers_busy_o=1, ers_req_ready_o=0.
  - rf_* pass the core write as in IDLE.
  - Then go to IDLE.
- rf_we_secure_o:
  - When rf_we_o=1, bit rf_waddr_o is 1 and all other bits are 0; when rf_we_o=0 it is 0.
  - Bit 0 is never set.
- Latency:
  - An N-register erase with no contention completes in N SCAN cycles; ers_done_o rises on cycle N+1 after acceptance.
  - With continuous contention the worst case is N·(StarveLimit+1) SCAN cycles.
- Boundaries:
  - A mask of 0 or only bit0 goes straight to DONE.
  - A request presented while busy is not accepted (ready=0).
  - wb_stall_o is never asserted outside SCAN.

Test Plan:
- Reset, idle passthrough: deassert reset; wb_we_i=1, waddr=5, wdata=0xDEADBEEF → rf_we_o=1, rf_waddr_o=5, rf_wdata_o=0xDEADBEEF, rf_we_secure_o=0x00000020. waddr=0 → rf_we_o=0.
- Uncontended erase: mask=0x0000000E, no core writes → zero-writes to x1, x2, x3 on consecutive cycles; ers_done_o pulses on the 4th cycle after acceptance; ready returns to 1 the following cycle.
- Starvation bound: StarveLimit=4, mask=0x00000100, wb_we_i=1 to x9 every cycle → 4 core writes pass; 5th cycle wb_stall_o=1 with a zero-write to x8; done pulses next cycle.
- Supersession: mask=0x00000030; in the first SCAN cycle the core writes x5=0x1234 → x5 not erased; only x4 is erased; final x5=0x1234.
- Degenerate mask and RV32E: mask=0x00000001 → DONE on the next cycle, no rf writes. With RV32E=1, mask=0x80010002 → only x1 is erased.
- Mid-sequence reset: mask=0xFFFFFFFE; assert rst_ni after 3 erases → outputs return to reset values immediately; no further erases after release.
